// File: rtl/fifo_event_reader.sv
// Read-side engine for the convolution event FIFO.
// Issues FIFO reads, absorbs the one-cycle registered read latency in a
// two-entry buffer and presents decoded events on a valid/ready stream.
//
// Handshake: an event transfers on a rising edge where out_valid and
// out_ready are both 1; while out_valid=1 and out_ready=0 every output holds.
module fifo_event_reader #(
    parameter int X_WIDTH    = 8,
    parameter int Y_WIDTH    = 8,
    parameter int DATA_WIDTH = X_WIDTH + Y_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_read_en,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [X_WIDTH-1:0]    out_x,
    output logic [Y_WIDTH-1:0]    out_y,
    output logic                  out_tstep,
    output logic [CNT_WIDTH-1:0]  event_count,
    output logic                  idle
);

    localparam logic [DATA_WIDTH-1:0] MARKER  = '1;
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);

    // buf0_q is always the head; buf1_q the second entry.
    logic [DATA_WIDTH-1:0] buf0_q;
    logic [DATA_WIDTH-1:0] buf1_q;
    logic [1:0]            count_q;
    logic                  in_flight_q;
    logic [CNT_WIDTH-1:0]  event_count_q;

    logic                  pop;
    logic [2:0]            occ_after;
    logic                  wr_to_head;
    logic                  is_marker;

    // Occupancy after this cycle's capture and pop; a read may be issued
    // only if the word it returns next cycle is guaranteed a slot.
    always_comb begin
        pop          = out_valid & out_ready;
        occ_after    = {1'b0, count_q} + {2'b0, in_flight_q} - {2'b0, pop};
        fifo_read_en = rst_n & enable & ~fifo_empty & (occ_after < 3'd2);
        // Arriving word lands in the head slot when the head is free after the pop.
        wr_to_head   = (count_q == 2'd0) | ((count_q == 2'd1) & pop);
    end

    // Buffer shift on pop, tail capture of the in-flight word, occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf0_q      <= '0;
            buf1_q      <= '0;
            count_q     <= 2'd0;
            in_flight_q <= 1'b0;
        end else begin
            if (pop) begin
                buf0_q <= buf1_q;
            end
            if (in_flight_q) begin
                if (wr_to_head) begin
                    buf0_q <= fifo_read_data;
                end else begin
                    buf1_q <= fifo_read_data;
                end
            end
            count_q     <= occ_after[1:0];
            in_flight_q <= fifo_read_en;
        end
    end

    // Decode the head word; fields are zero whenever nothing is presented
    // and for the end-of-timestep marker.
    always_comb begin
        out_valid = (count_q != 2'd0);
        is_marker = (buf0_q == MARKER);
        out_tstep = out_valid & is_marker;
        out_x     = '0;
        out_y     = '0;
        if (out_valid && !is_marker) begin
            out_x = buf0_q[DATA_WIDTH-1:Y_WIDTH];
            out_y = buf0_q[Y_WIDTH-1:0];
        end
        idle        = (count_q == 2'd0) & ~in_flight_q & fifo_empty;
        event_count = event_count_q;
    end

    // Data events since the last marker handoff; a marker handoff clears,
    // otherwise saturate at the all-ones value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_count_q <= '0;
        end else if (pop) begin
            if (out_tstep) begin
                event_count_q <= '0;
            end else if (event_count_q != CNT_MAX) begin
                event_count_q <= event_count_q + CNT_ONE;
            end
        end
    end

endmodule

// File: doc/fifo_event_reader.md
Name: fifo_event_reader

Overview:
- Read-side engine for the convolution event FIFO: drives the FIFO read port, absorbs its one-cycle registered read latency, and presents events on a valid/ready stream to the convolution core.
- Unpacks each FIFO word into x/y coordinates and recognises the all-ones word as an end-of-timestep marker.
- Sustains one event per cycle under no back-pressure and never loses or duplicates a word.

Parameters:
- X_WIDTH, 8, width of x coordinate field.
- Y_WIDTH, 8, width of y coordinate field.
- DATA_WIDTH, X_WIDTH+Y_WIDTH, FIFO word width; must equal X_WIDTH+Y_WIDTH.
- CNT_WIDTH, 16, width of the event counter.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  when 0, no new FIFO reads are issued; buffered and in-flight words still drain.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read_en  out  1  FIFO read request.
- fifo_read_data  in  DATA_WIDTH  FIFO read data, valid the cycle after a read is issued.
- out_valid  out  1  event available.
- out_ready  in  1  consumer accepts the event.
- out_x  out  X_WIDTH  event x = word[DATA_WIDTH-1:Y_WIDTH].
- out_y  out  Y_WIDTH  event y = word[Y_WIDTH-1:0].
- out_tstep  out  1  current output is an end-of-timestep marker; out_x and out_y are 0 when set.
- event_count  out  CNT_WIDTH  data events handed off since the last marker handoff.
- idle  out  1  no buffered word, no in-flight read, and fifo_empty=1.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_x=0, out_y=0, out_tstep=0, event_count=0.
  - Buffer empty, in_flight=0.
  - idle then follows fifo_empty.
  - fifo_read_en is 0 combinationally while rst_n=0.
- Buffer and in-flight tracking:
  - Internal 2-entry output buffer, occupancy count 0..2.
  - 1-bit in_flight register is set the cycle after fifo_read_en=1.
- Read issue (combinational):
  - pop = out_valid & out_ready.
  - fifo_read_en = enable & !fifo_empty & (count + in_flight - pop < 2).
  - This guarantees space for every in-flight word; the buffer never overflows.
- Capture:
  - When in_flight=1, fifo_read_data is written into the buffer tail that cycle.
  - Capture and pop may occur in the same cycle.
  - count_next = count + in_flight - pop.
- Output:
  - out_valid = (count != 0); outputs reflect the buffer head, decoded from the stored word.
  - Outputs hold stable while out_valid=1 and out_ready=0.
  - Latency: fifo_read_en at cycle N -> out_valid at cycle N+2 if the buffer was empty.
  - Throughput: 1 word/cycle with out_ready held at 1.
- Marker: a word of all ones sets out_tstep=1 and forces out_x=0, out_y=0.
- event_count:
  - Increments (saturating at 2^CNT_WIDTH-1) on each pop with out_tstep=0.
  - Is cleared to 0 on a pop with out_tstep=1; clear has priority over increment.
- enable deassert: takes effect the same cycle for new reads. An already-issued read is still captured and delivered.
- Reset mid-operation: buffered and in-flight words are discarded; the FIFO pointer has already advanced, so these words are lost by design. Upstream flushes the FIFO together with this block.
- Boundary conditions:
  - fifo_empty=1 -> no read.
  - count=2 with in_flight=0 and pop=0 -> no read.
  - count=1, in_flight=1, pop=1 -> read allowed.
  - Word arrival with out_ready=0 while count=1 -> word is stored as the second entry; no read is issued that cycle.

Test Plan:
- Reset, then FIFO preloaded with 0x0305, 0x0A01, 0xFFFF and out_ready=1 -> fifo_read_en for 3 consecutive cycles. Outputs appear 2 cycles after the first read:
  - (x=3, y=5, tstep=0)
  - (x=10, y=1, tstep=0)
  - (x=0, y=0, tstep=1)
  - event_count reads 0, 1, 2 before each handoff and 0 after the marker.
- 20 words queued, out_ready=1 throughout -> 20 consecutive out_valid cycles with no bubbles, order preserved.
- 8 words queued, out_ready toggled with a 3-cycles-low / 1-cycle-high pattern -> count never exceeds 2, outputs stable while stalled, all 8 delivered in order, none duplicated.
- enable=0 with a non-empty FIFO -> fifo_read_en stays 0 and idle=0. enable deasserted on the cycle after a read -> that word is still delivered.
- rst_n pulsed low asynchronously (mid-cycle) with count=2 and in_flight=1 -> out_valid=0 and event_count=0 immediately. After release, reading resumes from the next FIFO word.
- CNT_WIDTH=4, 17 data words followed by a marker -> event_count saturates at 15, then clears to 0 on the marker handoff.
